// File: rtl/dunit_pkg.sv
// Shared constants and state encoding for the debug-unit execution controller.
package dunit_pkg;

  // UART command bytes understood while the controller is idle
  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_CONT = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'

  // Instruction word that terminates a program load
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // Controller states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    LOAD_WR = 3'd2,
    RUN     = 3'd3,
    STEP    = 3'd4
  } state_t;

endpackage

// File: rtl/dunit_word_assembler.sv
// Collects UART bytes MSB-first into instruction words.
// o_word/o_word_valid are presented combinationally in the same cycle as the
// completing byte so the controller can register the write one cycle later.
module dunit_word_assembler #(
  parameter int NB_REG  = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_en,
  input  logic               i_valid,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic [NB_REG-1:0]  o_word,
  output logic               o_word_valid
);

  // Only the lower three bytes need storing; the fourth arrives live.
  logic [NB_REG-NB_BYTE-1:0] r_shift;
  logic [1:0]                r_cnt;
  logic [NB_REG-1:0]         w_word;
  logic                      w_take;

  // Form the candidate word and detect the completing (4th) byte
  always_comb begin
    w_word = {r_shift, i_byte};
    if (i_en && i_valid) begin
      w_take = 1'b1;
    end else begin
      w_take = 1'b0;
    end
    if (w_take && (r_cnt == 2'd3)) begin
      o_word_valid = 1'b1;
    end else begin
      o_word_valid = 1'b0;
    end
  end

  assign o_word = w_word;

  // Shift register and byte counter; count wraps to 0 after the 4th byte
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_shift <= '0;
      r_cnt   <= 2'd0;
    end else if (w_take) begin
      r_shift <= w_word[NB_REG-NB_BYTE-1:0];
      r_cnt   <= r_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/dunit_exec_ctrl.sv
// Debug-unit controller: loads programs into instruction memory from a UART
// byte stream and gates the pipeline clock for continuous or single-step runs.
module dunit_exec_ctrl
  import dunit_pkg::*;
#(
  parameter int                NB_REG    = 32,
  parameter int                NB_WIDHT  = 9,
  parameter int                NB_BYTE   = 8,
  parameter logic [NB_REG-1:0] HALT_WORD = dunit_pkg::HALT_WORD
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_valid,
  input  logic                i_halt,
  output logic                o_dunit_clk_en,
  output logic                o_dunit_w_en,
  output logic [NB_WIDHT-1:0] o_dunit_addr,
  output logic [NB_REG-1:0]   o_dunit_data,
  output logic                o_pipe_reset,
  output logic                o_load_done,
  output logic                o_err,
  output logic                o_halted
);

  // Highest word-aligned address and the per-word address increment
  localparam logic [NB_WIDHT-1:0] ADDR_LAST = {{(NB_WIDHT-2){1'b1}}, 2'b00};
  localparam logic [NB_WIDHT-1:0] ADDR_STEP = NB_WIDHT'(4);

  state_t              r_state;
  logic [NB_WIDHT-1:0] r_addr;       // address of the word being assembled
  logic [NB_WIDHT-1:0] r_wr_addr;    // address presented to memory
  logic [NB_REG-1:0]   r_wr_data;    // data presented to memory
  logic                r_w_en;
  logic                r_clk_en;
  logic                r_pipe_reset;
  logic                r_load_done;
  logic                r_err;
  logic                r_halted;

  logic                w_asm_clear;
  logic                w_asm_en;
  logic [NB_REG-1:0]   w_word;
  logic                w_word_valid;

  // Assembler control: cleared by a load command, fed only while loading
  always_comb begin
    if ((r_state == IDLE) && i_rx_valid && (i_rx_data == CMD_LOAD)) begin
      w_asm_clear = 1'b1;
    end else begin
      w_asm_clear = 1'b0;
    end
    if ((r_state == LOAD) || (r_state == LOAD_WR)) begin
      w_asm_en = 1'b1;
    end else begin
      w_asm_en = 1'b0;
    end
  end

  dunit_word_assembler #(
    .NB_REG  (NB_REG),
    .NB_BYTE (NB_BYTE)
  ) u_word_asm (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (w_asm_clear),
    .i_en         (w_asm_en),
    .i_valid      (i_rx_valid),
    .i_byte       (i_rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // Main FSM with address counter, sticky flags and registered strobes
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_w_en       <= 1'b0;
      r_clk_en     <= 1'b0;
      r_pipe_reset <= 1'b0;
      r_load_done  <= 1'b0;
      r_err        <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      // One-cycle strobes default low every cycle
      r_w_en       <= 1'b0;
      r_clk_en     <= 1'b0;
      r_pipe_reset <= 1'b0;
      r_load_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_LOAD: begin
                r_err    <= 1'b0;
                r_halted <= 1'b0;
                r_addr   <= '0;
                r_state  <= LOAD;
              end
              CMD_CONT: begin
                if (!r_halted) begin
                  r_clk_en <= 1'b1;
                  r_state  <= RUN;
                end
              end
              CMD_STEP: begin
                if (!r_halted) begin
                  r_clk_en <= 1'b1;
                  r_state  <= STEP;
                end
              end
              default: begin
                r_state <= IDLE;
              end
            endcase
          end
        end
        LOAD: begin
          // Latch address and data together so they stay stable after the write
          if (w_word_valid) begin
            r_w_en    <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= w_word;
            r_state   <= LOAD_WR;
          end
        end
        LOAD_WR: begin
          if (r_wr_data == HALT_WORD) begin
            r_load_done  <= 1'b1;
            r_pipe_reset <= 1'b1;
            r_state      <= IDLE;
          end else if (r_addr == ADDR_LAST) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_addr  <= r_addr + ADDR_STEP;
            r_state <= LOAD;
          end
        end
        RUN: begin
          // A sampled halt freezes the pipeline from the next cycle on
          if (i_halt) begin
            r_halted <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_clk_en <= 1'b1;
          end
        end
        STEP: begin
          if (i_halt) begin
            r_halted <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_dunit_clk_en = r_clk_en;
  assign o_dunit_w_en   = r_w_en;
  assign o_dunit_addr   = r_wr_addr;
  assign o_dunit_data   = r_wr_data;
  assign o_pipe_reset   = r_pipe_reset;
  assign o_load_done    = r_load_done;
  assign o_err          = r_err;
  assign o_halted       = r_halted;

endmodule
